// File: rtl/fsm_seq_pkg.sv
// Shared types, sizes and helpers for the sequence controller.
// Imported by the symbol buffer and the controller top.
package fsm_seq_pkg;

    localparam int DEPTH = 16;
    localparam int SIG_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        FRST,
        RUN,
        DONE
    } state_t;

    function automatic logic [SIG_W-1:0] rotl1(input logic [SIG_W-1:0] v);
        return {v[SIG_W-2:0], v[SIG_W-1]};
    endfunction

endpackage

// File: rtl/fsm_seq_symbuf.sv
// Stimulus symbol store: one write port that stops when full (no wrap),
// one combinational read port, contents cleared only by reset.
module fsm_seq_symbuf #(
    parameter int DEPTH = fsm_seq_pkg::DEPTH,
    localparam int IW = $clog2(DEPTH),
    localparam int PW = IW + 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          wr_en,
    input  logic [1:0]    wr_data,
    input  logic          clr_ptr,
    input  logic [IW-1:0] rd_idx,
    output logic [1:0]    rd_data
);

    logic [1:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic          wr_ok;

    assign wr_ok   = wr_en && (wr_ptr != PW'(DEPTH));
    assign rd_data = mem[rd_idx];

    // Store accepted symbols and advance the write pointer until full.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 2'd0;
            end
        end else begin
            if (wr_ok) begin
                mem[wr_ptr[IW-1:0]] <= wr_data;
            end
            if (clr_ptr) begin
                wr_ptr <= '0;
            end else if (wr_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
        end
    end

endmodule

// File: rtl/fsm_seq_ctrl.sv
// Sequence controller: resets the controlled FSM, replays buffered symbols
// and folds its responses into a rotate-xor signature for pass/fail.
module fsm_seq_ctrl #(
    parameter int DEPTH = fsm_seq_pkg::DEPTH,
    parameter int SIG_W = fsm_seq_pkg::SIG_W,
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             sym_wr,
    input  logic [1:0]       sym_data,
    input  logic             start,
    input  logic [LW-1:0]    len,
    input  logic [SIG_W-1:0] exp_sig,
    input  logic             abort,
    input  logic [SIG_W-1:0] rtext,
    output logic             fsm_rst,
    output logic [1:0]       ptext,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             aborted,
    output logic [SIG_W-1:0] sig
);

    import fsm_seq_pkg::*;

    localparam int IW = LW - 1;

    state_t           state, state_n;
    logic [LW-1:0]    len_q;
    logic [LW-1:0]    k;
    logic [SIG_W-1:0] exp_q;
    logic [SIG_W-1:0] sig_n;
    logic [1:0]       rd_data;
    logic             last;
    logic             wr_en;
    logic             clr_ptr;

    assign sig_n   = rotl1(sig) ^ rtext;
    assign last    = (k == len_q - LW'(1));
    assign fsm_rst = RST | (state == FRST);

    fsm_seq_symbuf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .CLK     (CLK),
        .RST     (RST),
        .wr_en   (wr_en),
        .wr_data (sym_data),
        .clr_ptr (clr_ptr),
        .rd_idx  (k[IW-1:0]),
        .rd_data (rd_data)
    );

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and per-state outputs; buffer pointer clears on entering DONE.
    always_comb begin
        state_n = state;
        wr_en   = 1'b0;
        clr_ptr = 1'b0;
        ptext   = 2'd0;
        busy    = 1'b1;
        done    = 1'b0;
        unique case (state)
            IDLE: begin
                busy  = 1'b0;
                wr_en = sym_wr;
                if (start) begin
                    state_n = FRST;
                end
            end
            FRST: begin
                if (len_q == '0) begin
                    state_n = DONE;
                    clr_ptr = 1'b1;
                end else begin
                    state_n = RUN;
                end
            end
            RUN: begin
                ptext = rd_data;
                if (abort || last) begin
                    state_n = DONE;
                    clr_ptr = 1'b1;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Run bookkeeping: latch on start, accumulate in RUN, resolve pass at the end.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            len_q   <= '0;
            exp_q   <= '0;
            sig     <= '0;
            pass    <= 1'b0;
            aborted <= 1'b0;
            k       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        len_q   <= (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
                        exp_q   <= exp_sig;
                        sig     <= '0;
                        pass    <= 1'b0;
                        aborted <= 1'b0;
                        k       <= '0;
                    end
                end
                FRST: begin
                    if (len_q == '0) begin
                        pass <= (exp_q == '0);
                    end
                end
                RUN: begin
                    if (abort) begin
                        aborted <= 1'b1;
                    end else begin
                        sig <= sig_n;
                        k   <= k + LW'(1);
                        if (last) begin
                            pass <= (sig_n == exp_q);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// Scoreboard bench for fsm_seq_ctrl: a symbol/signature model predicts each
// run's outcome, which is queued at start and compared when done appears.
module tb_fsm_seq_ctrl;

    localparam int DEPTH = 16;

    typedef struct {
        int         lat;
        logic       pass;
        logic       aborted;
        logic [7:0] sig;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST;
    logic       sym_wr;
    logic [1:0] sym_data;
    logic       start;
    logic [4:0] len;
    logic [7:0] exp_sig;
    logic       abort;
    logic [7:0] rtext;
    logic       fsm_rst;
    logic [1:0] ptext;
    logic       busy;
    logic       done;
    logic       pass;
    logic       aborted;
    logic [7:0] sig;

    logic       mode;
    logic [1:0] mbuf [DEPTH];
    int         nst;
    exp_t       sb [$];
    int         total = 0;
    int         bad = 0;

    fsm_seq_ctrl dut (
        .CLK      (CLK),
        .RST      (RST),
        .sym_wr   (sym_wr),
        .sym_data (sym_data),
        .start    (start),
        .len      (len),
        .exp_sig  (exp_sig),
        .abort    (abort),
        .rtext    (rtext),
        .fsm_rst  (fsm_rst),
        .ptext    (ptext),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .aborted  (aborted),
        .sig      (sig)
    );

    always #5 CLK = ~CLK;

    // Controlled-FSM stand-in: constant 01, or a word derived from ptext.
    assign rtext = mode ? {4'ha, 2'b00, ptext} : 8'h01;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] rt(input logic [1:0] p);
        return mode ? {4'ha, 2'b00, p} : 8'h01;
    endfunction

    function automatic logic [7:0] acc(input int n);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < n; i++) begin
            s = {s[6:0], s[7]} ^ rt(mbuf[i]);
        end
        return s;
    endfunction

    task automatic store(input logic [1:0] s);
        if (nst < DEPTH) begin
            mbuf[nst] = s;
            nst++;
        end
    endtask

    task automatic wr(input logic [1:0] s);
        @(negedge CLK);
        sym_wr   = 1'b1;
        sym_data = s;
        store(s);
        @(posedge CLK);
        #1 sym_wr = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_done"}, 32'(done), 32'(0));
        chk({tag, "_ptext"}, 32'(ptext), 32'(0));
        chk({tag, "_frst"}, 32'(fsm_rst), 32'(RST));
    endtask

    // ab < 0: no abort; otherwise abort in RUN cycle ab.
    task automatic run(input int l, input logic [7:0] e, input int ab,
                       input bit ws, input logic [1:0] wsym);
        int   nsat, nrun, npt, c, n;
        bit   seen;
        exp_t x, y;
        nsat = (l > DEPTH) ? DEPTH : l;
        if (ws) store(wsym);
        nrun      = (ab >= 0) ? ab : nsat;
        npt       = (ab >= 0) ? ab + 1 : nsat;
        x.lat     = (ab >= 0) ? ab + 3 : nsat + 2;
        x.sig     = acc(nrun);
        x.aborted = (ab >= 0);
        x.pass    = (ab < 0) && (x.sig == e);
        sb.push_back(x);
        @(negedge CLK);
        start    = 1'b1;
        len      = 5'(l);
        exp_sig  = e;
        sym_wr   = ws;
        sym_data = wsym;
        @(negedge CLK);
        c        = 1;
        sym_wr   = 1'b1;
        sym_data = 2'd3;
        seen     = 1'b0;
        while (!seen && c <= 40) begin
            n = (c - 2 < nrun) ? c - 2 : nrun;
            if (n < 0) n = 0;
            chk("fsm_rst", 32'(fsm_rst), 32'(c == 1));
            chk("busy", 32'(busy), 32'(1));
            chk("sig_step", 32'(sig), 32'(acc(n)));
            if (c >= 2 && c - 2 < npt)
                chk("ptext", 32'(ptext), 32'(mbuf[c-2]));
            else
                chk("ptext_zero", 32'(ptext), 32'(0));
            if (done) begin
                y = sb.pop_front();
                chk("lat", 32'(c), 32'(y.lat));
                chk("pass", 32'(pass), 32'(y.pass));
                chk("aborted", 32'(aborted), 32'(y.aborted));
                chk("sig", 32'(sig), 32'(y.sig));
                seen = 1'b1;
            end else begin
                @(negedge CLK);
                c++;
                start  = 1'b0;
                sym_wr = 1'b0;
                abort  = (ab >= 0) && (c == ab + 2);
            end
        end
        start  = 1'b0;
        sym_wr = 1'b0;
        abort  = 1'b0;
        if (!seen) begin
            chk("done_timeout", 32'(0), 32'(1));
            y = sb.pop_front();
        end
        nst = 0;
        @(negedge CLK);
        chk_idle("after");
        chk("hold_pass", 32'(pass), 32'(x.pass));
        chk("hold_abrt", 32'(aborted), 32'(x.aborted));
        chk("hold_sig", 32'(sig), 32'(x.sig));
    endtask

    task automatic clr_model();
        for (int i = 0; i < DEPTH; i++) mbuf[i] = 2'd0;
        nst = 0;
    endtask

    initial begin
        RST = 1'b1; sym_wr = 1'b0; sym_data = 2'd0; start = 1'b0;
        len = 5'd0; exp_sig = 8'h00; abort = 1'b0; mode = 1'b0;
        clr_model();
        repeat (2) @(negedge CLK);
        chk_idle("rst");
        chk("rst_sig", 32'(sig), 32'(0));
        chk("rst_pass", 32'(pass), 32'(0));
        chk("rst_abrt", 32'(aborted), 32'(0));
        RST = 1'b0;
        @(negedge CLK);
        chk_idle("post_rst");

        // Constant response, matching and mismatching signatures.
        for (int i = 1; i <= 3; i++) wr(2'(i));
        run(3, 8'h07, -1, 1'b0, 2'd0);
        for (int i = 1; i <= 3; i++) wr(2'(i));
        run(3, 8'h06, -1, 1'b0, 2'd0);

        // Symbol replay order with data-dependent response.
        mode = 1'b1;
        wr(2'd1); wr(2'd2); wr(2'd3); wr(2'd0);
        run(4, 8'h00, -1, 1'b0, 2'd0);

        // Overfill the buffer and saturate len.
        for (int i = 0; i < 18; i++) wr(2'(3 - (i % 4)));
        run(20, acc(16), -1, 1'b0, 2'd0);

        // No writes: contents persist from the previous fill.
        run(4, acc(4), -1, 1'b0, 2'd0);

        // Abort in RUN cycle 1 of a len=5 run.
        mode = 1'b0;
        for (int i = 0; i < 5; i++) wr(2'(i));
        run(5, 8'h1f, 1, 1'b0, 2'd0);

        // Write together with start; abort while idle is ignored.
        mode = 1'b1;
        wr(2'd2); wr(2'd1);
        @(negedge CLK); abort = 1'b1;
        @(negedge CLK); abort = 1'b0;
        chk("idle_abort", 32'(aborted), 32'(1));
        run(3, 8'h00, -1, 1'b1, 2'd3);

        // Reset in the middle of a run.
        mode = 1'b0;
        for (int i = 0; i < 3; i++) wr(2'(i + 1));
        @(negedge CLK);
        start = 1'b1; len = 5'd5; exp_sig = 8'h00;
        @(negedge CLK);
        start = 1'b0;
        repeat (3) @(negedge CLK);
        chk("mid_busy", 32'(busy), 32'(1));
        RST = 1'b1;
        #1;
        clr_model();
        chk_idle("mid_rst");
        chk("mid_sig", 32'(sig), 32'(0));
        chk("mid_pass", 32'(pass), 32'(0));
        chk("mid_abrt", 32'(aborted), 32'(0));
        @(negedge CLK);
        RST = 1'b0;

        // Zero-length runs, then a run over the cleared buffer.
        run(0, 8'h00, -1, 1'b0, 2'd0);
        run(0, 8'h5a, -1, 1'b0, 2'd0);
        mode = 1'b1;
        run(3, 8'h63, -1, 1'b0, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fsm_seq_ctrl.md
FSM_SEQ_CTRL -- requirements
Module: fsm_seq_ctrl

Interface
REQ-001 Parameter DEPTH, 16, symbol buffer entries; len field width is clog2(DEPTH)+1.
REQ-002 Parameter SIG_W, 8, width of the response word and the signature.
REQ-003 CLK  in  1  single clock; all state changes on the rising edge.
REQ-004 RST  in  1  reset, asynchronous and active-high.
REQ-005 sym_wr  in  1  write one stimulus symbol into the buffer; honoured only in IDLE.
REQ-006 sym_data  in  2  stimulus symbol written on sym_wr.
REQ-007 start  in  1  begin a run; honoured only in IDLE.
REQ-008 len  in  5  number of symbols to apply; sampled on start; values above DEPTH saturate to DEPTH.
REQ-009 exp_sig  in  8  expected signature; sampled on start.
REQ-010 abort  in  1  terminate a run early; honoured only in RUN.
REQ-011 rtext  in  8  response word from the controlled FSM.
REQ-012 fsm_rst  out  1  reset to the controlled FSM.
REQ-013 ptext  out  2  stimulus symbol to the controlled FSM.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle completion pulse.
REQ-016 pass  out  1  compare result; valid from done and held until the next start.
REQ-017 aborted  out  1  set when the last run ended by abort; held until the next start.
REQ-018 sig  out  8  accumulated signature; held until the next start.

Function
REQ-019 States: IDLE, FRST, RUN, DONE.
- IDLE -> FRST on start.
- FRST -> RUN, or FRST -> DONE when the saturated len is 0.
- RUN -> DONE after len cycles or on abort.
- DONE -> IDLE unconditionally.
REQ-020 Writes in IDLE store sym_data at wr_ptr and increment wr_ptr.
- When wr_ptr equals DEPTH, further writes are dropped; there is no wrap.
REQ-021 Buffer contents persist across runs; wr_ptr clears to 0 on entering DONE.
REQ-022 On start: latch len (saturated), exp_sig, clear sig to 0, clear pass, clear aborted, clear rd_idx.
REQ-023 FRST lasts exactly one cycle with fsm_rst=1 and ptext=0.
REQ-024 RUN cycle k (k = 0..len-1) drives ptext = buf[k].
- At the end of that cycle, sig <= rotl1(sig) XOR rtext.
REQ-025 On the edge that ends the last RUN cycle, pass <= (new sig == latched exp_sig).
REQ-026 Timing: start is sampled at edge E0.
- FRST is cycle 1; RUN is cycles 2..len+1; done=1 in cycle len+2.
- The next start is accepted from cycle len+3.
REQ-027 abort in RUN cycle k: that cycle's rtext is not accumulated; DONE follows with pass=0 and aborted=1.
REQ-028 len=0: FRST -> DONE; pass = (exp_sig == 0).
REQ-029 start and sym_wr in the same IDLE cycle: the write is stored first, then the run starts.
REQ-030 start, sym_wr and abort are ignored outside the states in which they are honoured.
REQ-031 ptext=0 in every state other than RUN.
REQ-032 fsm_rst = RST OR (state == FRST).

Reset
REQ-033 RST asserted at any time, including mid-run, forces IDLE at once with:
- wr_ptr=0, sig=0, pass=0, aborted=0, done=0, busy=0, ptext=0, fsm_rst=1.
REQ-034 Buffer entries reset to 0.

Structure
REQ-035 Package fsm_seq_pkg holds: state enum, DEPTH, SIG_W and the rotl1 function.
REQ-036 Sub-module fsm_seq_symbuf holds the buffer with one write port, one read port and wr_ptr saturation.

Verification
REQ-037 Model rtext = 8'h01 constant; write 3 symbols; start with len=3 and exp_sig=8'h07.
- sig sequence 01, 03, 07; done in cycle 5; pass=1.
REQ-038 Same run with exp_sig=8'h06 -> pass=0, sig=8'h07, aborted=0.
REQ-039 Write symbols 1,2,3,0; start with len=4.
- ptext = 1,2,3,0 in cycles 2-5; fsm_rst=1 in cycle 1 only.
REQ-040 Write 18 symbols -> only the first 16 are stored.
- Start with len=20 -> 16 RUN cycles; done in cycle 18.
REQ-041 abort in RUN cycle k=1 of a len=5 run -> done the next cycle; pass=0, aborted=1, sig=8'h01.
REQ-042 RST pulsed in RUN -> IDLE at once, all outputs at reset values.
- A later start with len=0 and exp_sig=0 -> done in cycle 2 with pass=1.
